branch_predictor: RTL and testbench

Parametrised two-level adaptive branch predictor that sits beside the fetch stage of the pipelined core and is queried once per fetched instruction.
- Provides a configurable pattern history table (PHT) with a global history register and a selectable indexing mode (concatenated or gshare).
- Provides a tagged branch target buffer (BTB) with valid bits.
- Adds a return address stack (RAS), a table-initialisation FSM, and hit/miss statistics counters.
- Receives resolution updates from the execute stage.

---
 rtl/bp_pkg.sv | 39 +++
 rtl/bp_ras.sv | 50 +++++
 rtl/branch_predictor.sv | 156 +++++++++++++++
 tb/tb_branch_predictor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the two-level branch predictor.
// Table fields are held at FIELD_W bits; the top trims them to ADDR_W/IDX_W.
package bp_pkg;

  localparam int MODE_CONCAT = 0;
  localparam int MODE_GSHARE = 1;
  localparam int FIELD_W     = 32;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [FIELD_W-1:0] tag;
    logic [FIELD_W-1:0] target;
  } btb_entry_t;

  function automatic logic [FIELD_W-1:0] pht_index(
    input logic [FIELD_W-1:0] pc_idx,
    input logic [FIELD_W-1:0] hist,
    input int                 hist_w,
    input int                 mode
  );
    if (mode == MODE_GSHARE) return pc_idx ^ hist;
    return (pc_idx << hist_w) | hist;
  endfunction

  function automatic logic [FIELD_W-1:0] sat_step(
    input logic [FIELD_W-1:0] ctr,
    input logic               up,
    input logic [FIELD_W-1:0] max
  );
    if (up) return (ctr == max) ? ctr : ctr + 1;
    return (ctr == '0) ? ctr : ctr - 1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return address stack; a push when full overwrites the oldest entry.
module bp_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              nonempty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_pop;

  assign top_ptr  = ptr - 1'b1;
  assign nonempty = (count != '0);
  assign top      = mem[top_ptr];
  assign do_pop   = pop && nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_pop && push) begin
      // pop followed by push: top replaced in place, pointer and count unchanged
      ptr   <= ptr;
      count <= count;
    end else if (do_pop) begin
      ptr   <= top_ptr;
      count <= count - 1'b1;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? top_ptr : ptr] <= push_data;
  end

endmodule

// File: rtl/branch_predictor.sv
// Two-level adaptive branch predictor: PHT + global history, tagged BTB, RAS,
// table-initialisation FSM and resolution statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 8,
  parameter int HIST_W    = 2,
  parameter int CTR_W     = 2,
  parameter int MODE      = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_is_br,
  input  logic              f_is_call,
  input  logic              f_is_ret,
  output logic              p_taken,
  output logic [ADDR_W-1:0] p_target,
  output logic [HIST_W-1:0] p_hist,
  input  logic              u_valid,
  input  logic [ADDR_W-1:0] u_pc,
  input  logic [HIST_W-1:0] u_hist,
  input  logic              u_taken,
  input  logic [ADDR_W-1:0] u_target,
  input  logic              u_mispredict,
  output logic [31:0]       stat_total,
  output logic [31:0]       stat_hit,
  output logic [31:0]       stat_miss
);

  // state   | meaning
  // ST_INIT | sweeping PHT to weakly-not-taken and clearing BTB valid bits
  // ST_RUN  | predicting and accepting resolution updates

  localparam int PHT_W = (MODE == MODE_GSHARE) ? IDX_W : IDX_W + HIST_W;
  localparam int PHT_N = 1 << PHT_W;
  localparam int BTB_N = 1 << IDX_W;
  localparam logic [CTR_W-1:0]   CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [FIELD_W-1:0] CTR_MAX  = FIELD_W'((1 << CTR_W) - 1);

  state_t            state, state_nxt;
  logic [PHT_W-1:0]  init_idx;
  logic              init_in_btb;
  logic [HIST_W-1:0] hist;
  logic [HIST_W:0]   hist_shift;
  logic [CTR_W-1:0]  pht [PHT_N];
  btb_entry_t        btb [BTB_N];

  logic               fetch_en, upd_en;
  logic [IDX_W-1:0]   f_idx, u_idx;
  logic [FIELD_W-1:0] f_pi_full, u_pi_full, u_ctr_full;
  logic [PHT_W-1:0]   f_pht_idx, u_pht_idx;
  logic               f_ctr_msb;
  btb_entry_t         btb_rd;
  logic               btb_hit;
  logic [ADDR_W-1:0]  ras_top;
  logic               ras_nonempty;
  logic               unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_idx == '1) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    init_idx <= '0;
    else if (state == ST_INIT)  init_idx <= init_idx + 1'b1;
  end

  assign ready       = (state == ST_RUN);
  assign init_in_btb = ((FIELD_W'(init_idx) >> IDX_W) == '0);
  assign fetch_en    = ready & f_valid;
  assign upd_en      = ready & u_valid;

  assign f_idx      = f_pc[IDX_W-1:0];
  assign u_idx      = u_pc[IDX_W-1:0];
  assign f_pi_full  = pht_index(FIELD_W'(f_idx), FIELD_W'(hist), HIST_W, MODE);
  assign u_pi_full  = pht_index(FIELD_W'(u_idx), FIELD_W'(u_hist), HIST_W, MODE);
  assign f_pht_idx  = f_pi_full[PHT_W-1:0];
  assign u_pht_idx  = u_pi_full[PHT_W-1:0];
  assign f_ctr_msb  = pht[f_pht_idx][CTR_W-1];
  assign u_ctr_full = sat_step(FIELD_W'(pht[u_pht_idx]), u_taken, CTR_MAX);
  assign btb_rd     = btb[f_idx];
  assign btb_hit    = btb_rd.valid && (btb_rd.tag == FIELD_W'(f_pc[ADDR_W-1:IDX_W]));
  assign unused_bits = ^{f_pi_full[FIELD_W-1:PHT_W], u_pi_full[FIELD_W-1:PHT_W],
                         u_ctr_full[FIELD_W-1:CTR_W]};

  always_comb begin
    p_taken  = 1'b0;
    p_target = f_pc + ADDR_W'(1);
    if (fetch_en) begin
      if (f_is_ret && ras_nonempty) begin
        p_taken  = 1'b1;
        p_target = ras_top;
      end else if (f_is_br && f_ctr_msb && btb_hit) begin
        p_taken  = 1'b1;
        p_target = btb_rd.target[ADDR_W-1:0];
      end
    end
  end

  assign p_hist = hist;

  // Tables carry no reset; INIT sweeps them before any prediction is trusted.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      pht[init_idx] <= CTR_INIT;
      if (init_in_btb) btb[init_idx[IDX_W-1:0]].valid <= 1'b0;
    end else if (u_valid) begin
      pht[u_pht_idx] <= u_ctr_full[CTR_W-1:0];
      if (u_taken)
        btb[u_idx] <= '{valid: 1'b1,
                        tag: FIELD_W'(u_pc[ADDR_W-1:IDX_W]),
                        target: FIELD_W'(u_target)};
    end
  end

  assign hist_shift = {hist, u_taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist       <= '0;
      stat_total <= '0;
      stat_hit   <= '0;
      stat_miss  <= '0;
    end else if (upd_en) begin
      hist       <= hist_shift[HIST_W-1:0];
      stat_total <= stat_total + 32'd1;
      if (u_mispredict) stat_miss <= stat_miss + 32'd1;
      else              stat_hit  <= stat_hit + 32'd1;
    end
  end

  bp_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch_en & f_is_call),
    .pop       (fetch_en & f_is_ret),
    .push_data (f_pc + ADDR_W'(1)),
    .top       (ras_top),
    .nonempty  (ras_nonempty)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + randomized bench for branch_predictor (default parameters),
// checked against a table/queue-based reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready;
  logic        f_valid = 1'b0, f_is_br = 1'b0, f_is_call = 1'b0, f_is_ret = 1'b0;
  logic [31:0] f_pc = '0;
  logic        p_taken;
  logic [31:0] p_target;
  logic [1:0]  p_hist;
  logic        u_valid = 1'b0, u_taken = 1'b0, u_mispredict = 1'b0;
  logic [31:0] u_pc = '0, u_target = '0;
  logic [1:0]  u_hist = '0;
  logic [31:0] stat_total, stat_hit, stat_miss;

  branch_predictor dut (
    .clk(clk), .rst(rst), .ready(ready),
    .f_valid(f_valid), .f_pc(f_pc), .f_is_br(f_is_br), .f_is_call(f_is_call),
    .f_is_ret(f_is_ret), .p_taken(p_taken), .p_target(p_target), .p_hist(p_hist),
    .u_valid(u_valid), .u_pc(u_pc), .u_hist(u_hist), .u_taken(u_taken),
    .u_target(u_target), .u_mispredict(u_mispredict),
    .stat_total(stat_total), .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // reference model state
  int          pht_m [1024];
  bit          btb_v [256];
  logic [31:0] btb_tag_m [256];
  logic [31:0] btb_tgt_m [256];
  logic [31:0] ras_q [$];
  int          hist_m;
  bit          m_ready;
  int          init_cnt;
  logic [31:0] m_total, m_hit, m_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pidx(input logic [31:0] pc, input int h);
    return int'(pc % 256) * 4 + h;
  endfunction

  task automatic model_reset();
    m_ready  = 1'b0;
    init_cnt = 0;
    hist_m   = 0;
    ras_q.delete();
    m_total  = '0;
    m_hit    = '0;
    m_miss   = '0;
  endtask

  task automatic model_edge();
    int k, b;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_ready) begin
      init_cnt++;
      if (init_cnt == 1024) begin
        m_ready = 1'b1;
        foreach (pht_m[i]) pht_m[i] = 1;
        foreach (btb_v[i]) btb_v[i] = 1'b0;
      end
      return;
    end
    if (f_valid) begin
      if (f_is_ret && ras_q.size() > 0) void'(ras_q.pop_back());
      if (f_is_call) begin
        ras_q.push_back(f_pc + 32'd1);
        if (ras_q.size() > 4) void'(ras_q.pop_front());
      end
    end
    if (u_valid) begin
      k = pidx(u_pc, int'(u_hist));
      if (u_taken) pht_m[k] = (pht_m[k] < 3) ? pht_m[k] + 1 : 3;
      else         pht_m[k] = (pht_m[k] > 0) ? pht_m[k] - 1 : 0;
      hist_m = (hist_m * 2 + int'(u_taken)) % 4;
      if (u_taken) begin
        b = int'(u_pc % 256);
        btb_v[b]     = 1'b1;
        btb_tag_m[b] = u_pc >> 8;
        btb_tgt_m[b] = u_target;
      end
      m_total++;
      if (u_mispredict) m_miss++;
      else              m_hit++;
    end
  endtask

  task automatic expect_pred(output logic exp_t, output logic [31:0] exp_tgt);
    int b;
    exp_t   = 1'b0;
    exp_tgt = f_pc + 32'd1;
    b = int'(f_pc % 256);
    if (m_ready && f_valid) begin
      if (f_is_ret && ras_q.size() > 0) begin
        exp_t   = 1'b1;
        exp_tgt = ras_q[$];
      end else if (f_is_br && pht_m[pidx(f_pc, hist_m)] >= 2 && btb_v[b] &&
                   btb_tag_m[b] == (f_pc >> 8)) begin
        exp_t   = 1'b1;
        exp_tgt = btb_tgt_m[b];
      end
    end
  endtask

  task automatic check_outputs();
    logic        et;
    logic [31:0] eg;
    expect_pred(et, eg);
    chk("ready", ready, m_ready);
    chk("p_taken", p_taken, et);
    chk("p_target", p_target, eg);
    chk("p_hist", p_hist, hist_m[1:0]);
    chk("stat_total", stat_total, m_total);
    chk("stat_hit", stat_hit, m_hit);
    chk("stat_miss", stat_miss, m_miss);
  endtask

  // inputs are set at the falling edge; outputs checked 1 unit later
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    f_valid = 1'b0; f_is_br = 1'b0; f_is_call = 1'b0; f_is_ret = 1'b0;
    u_valid = 1'b0; u_taken = 1'b0; u_mispredict = 1'b0;
  endtask

  initial begin
    logic [3:0]  mp;
    int          hs [3];
    logic [31:0] ret_exp [4];
    mp = 4'b0100;
    hs = '{0, 1, 3};
    ret_exp = '{32'h25, 32'h24, 32'h23, 32'h22};

    // 1. reset and init sweep
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    f_valid = 1'b1; f_pc = 32'h10; f_is_br = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (1024) tick();
    chk("s1_ready_after_init", ready, 1'b1);

    // 6a. statistics
    idle();
    for (int i = 0; i < 4; i++) begin
      u_valid = 1'b1; u_pc = 32'h50; u_taken = 1'b0; u_hist = 2'b00;
      u_mispredict = mp[i];
      tick();
    end
    idle();
    chk("s6_total", stat_total, 32'd4);
    chk("s6_hit", stat_hit, 32'd3);
    chk("s6_miss", stat_miss, 32'd1);

    // 2. training
    for (int i = 0; i < 3; i++) begin
      u_valid = 1'b1; u_pc = 32'h10; u_taken = 1'b1; u_target = 32'h40;
      u_hist = 2'(hs[i]);
      tick();
    end
    idle();
    f_valid = 1'b1; f_pc = 32'h10; f_is_br = 1'b1;
    #1;
    chk("s2_taken", p_taken, 1'b1);
    chk("s2_target", p_target, 32'h40);
    chk("s2_hist", p_hist, 2'b11);
    tick();

    // 4. BTB tag mismatch
    f_pc = 32'h110;
    #1;
    chk("s4_taken", p_taken, 1'b0);
    chk("s4_target", p_target, 32'h111);
    tick();

    // 3. saturation
    idle();
    repeat (5) begin
      u_valid = 1'b1; u_pc = 32'h10; u_taken = 1'b1; u_target = 32'h40; u_hist = 2'b11;
      tick();
    end
    idle();
    f_valid = 1'b1; f_pc = 32'h10; f_is_br = 1'b1;
    #1;
    chk("s3_sat_taken", p_taken, 1'b1);
    tick();
    idle();
    repeat (4) begin
      u_valid = 1'b1; u_pc = 32'h10; u_taken = 1'b0; u_hist = 2'b11;
      tick();
    end
    repeat (2) begin
      u_valid = 1'b1; u_pc = 32'h33; u_taken = 1'b1; u_target = 32'h99; u_hist = 2'b00;
      tick();
    end
    idle();
    f_valid = 1'b1; f_pc = 32'h10; f_is_br = 1'b1;
    #1;
    chk("s3_nt_hist", p_hist, 2'b11);
    chk("s3_nt_taken", p_taken, 1'b0);
    tick();

    // 5. RAS overflow / underflow
    idle();
    for (int i = 0; i < 5; i++) begin
      f_valid = 1'b1; f_is_call = 1'b1; f_pc = 32'h20 + 32'(i);
      tick();
    end
    f_is_call = 1'b0; f_is_ret = 1'b1; f_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("s5_ret_taken", p_taken, 1'b1);
      chk("s5_ret_target", p_target, ret_exp[i]);
      tick();
    end
    #1;
    chk("s5_empty_taken", p_taken, 1'b0);
    chk("s5_empty_target", p_target, 32'h81);
    tick();

    // randomized traffic
    repeat (1500) begin
      f_valid      = ($urandom_range(0, 3) != 0);
      f_pc         = (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 15));
      f_is_br      = $urandom_range(0, 1) == 1;
      f_is_call    = $urandom_range(0, 5) == 0;
      f_is_ret     = $urandom_range(0, 4) == 0;
      u_valid      = $urandom_range(0, 1) == 1;
      u_pc         = (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 15));
      u_hist       = 2'($urandom_range(0, 3));
      u_taken      = $urandom_range(0, 1) == 1;
      u_target     = $urandom;
      u_mispredict = $urandom_range(0, 2) == 0;
      tick();
    end

    // 6b. reset mid-RUN
    idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("s6_rst_ready", ready, 1'b0);
    chk("s6_rst_total", stat_total, 32'd0);
    chk("s6_rst_hit", stat_hit, 32'd0);
    chk("s6_rst_miss", stat_miss, 32'd0);
    tick();
    rst = 1'b0;
    f_valid = 1'b1; f_pc = 32'h10; f_is_br = 1'b1;
    repeat (1024) tick();
    chk("s6_ready_after_reinit", ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
